// File: rtl/alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : alu_dispatch
// Purpose  : Operation buffer and result stage wrapped around the external
//            32-bit combinational ALU in the execute path.
//            - Operations (command, operand A/B, tag) arrive over a
//              valid/ready handshake and are queued in a DEPTH-entry FIFO.
//            - The FIFO head drives the ALU combinationally.
//            - The ALU result and flags are captured into a one-entry output
//              stage and returned in order over a second valid/ready handshake.
//            - A sticky overflow flag records any retired overflow.
// Ports    :
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               operation handshake
//   in_command/in_operand_a/b/tag   operation payload
//   alu_command/alu_operand_a/b     head entry presented to the ALU
//   alu_result/carryout/zero/ovf    ALU response
//   out_valid/out_ready             result handshake
//   out_result/carryout/zero/ovf    registered result and flags
//   out_tag                         tag returned with the result
//   occupancy                       FIFO entry count (output stage excluded)
//   sticky_overflow/sticky_clear    sticky overflow status and its clear
// Revision : 1.0 - initial release
// ============================================================================
module alu_dispatch #(
  parameter int DEPTH = 4,  // FIFO entries, power of two, >= 2
  parameter int TAGW  = 4   // tag width
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_command,
  input  logic [31:0]              in_operand_a,
  input  logic [31:0]              in_operand_b,
  input  logic [TAGW-1:0]          in_tag,

  output logic [2:0]               alu_command,
  output logic [31:0]              alu_operand_a,
  output logic [31:0]              alu_operand_b,
  input  logic [31:0]              alu_result,
  input  logic                     alu_carryout,
  input  logic                     alu_zero,
  input  logic                     alu_overflow,

  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_carryout,
  output logic                     out_zero,
  output logic                     out_overflow,
  output logic [TAGW-1:0]          out_tag,

  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     sticky_overflow,
  input  logic                     sticky_clear
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [2:0]    CMD_ADD  = 3'b000;

  // --------------------------------------------------------------------------
  // FIFO storage and pointers
  // --------------------------------------------------------------------------
  logic [2:0]      cmd_mem_q [DEPTH];
  logic [31:0]     opa_mem_q [DEPTH];
  logic [31:0]     opb_mem_q [DEPTH];
  logic [TAGW-1:0] tag_mem_q [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Output stage
  logic            out_valid_q,    out_valid_d;
  logic [31:0]     out_result_q,   out_result_d;
  logic            out_carry_q,    out_carry_d;
  logic            out_zero_q,     out_zero_d;
  logic            out_ovf_q,      out_ovf_d;
  logic [TAGW-1:0] out_tag_q,      out_tag_d;
  logic            sticky_q,       sticky_d;

  logic            fifo_empty;
  logic            push;
  logic            load;

  // Ready depends only on the registered count: a full FIFO refuses a push
  // even when a pop happens on the same edge, which keeps in_valid out of
  // the in_ready path.
  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid & in_ready;

  // The head moves into the output stage whenever the stage is free or is
  // being drained this edge. Only registered count is used, so an entry
  // pushed into an empty FIFO waits one edge (no fall-through).
  assign load       = ~fifo_empty & (~out_valid_q | out_ready);

  // --------------------------------------------------------------------------
  // ALU drive: head entry, or an all-zero ADD when the FIFO is empty
  // --------------------------------------------------------------------------
  always_comb begin
    alu_command   = CMD_ADD;
    alu_operand_a = '0;
    alu_operand_b = '0;
    if (!fifo_empty) begin
      alu_command   = cmd_mem_q[rd_ptr_q];
      alu_operand_a = opa_mem_q[rd_ptr_q];
      alu_operand_b = opb_mem_q[rd_ptr_q];
    end
  end

  // --------------------------------------------------------------------------
  // FIFO next state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (load) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset: an entry is only ever read after the
  // pointers say it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem_q[wr_ptr_q] <= in_command;
      opa_mem_q[wr_ptr_q] <= in_operand_a;
      opb_mem_q[wr_ptr_q] <= in_operand_b;
      tag_mem_q[wr_ptr_q] <= in_tag;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage next state
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_zero_d   = out_zero_q;
    out_ovf_d    = out_ovf_q;
    out_tag_d    = out_tag_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_carry_d  = alu_carryout;
      out_zero_d   = alu_zero;
      out_ovf_d    = alu_overflow;
      out_tag_d    = tag_mem_q[rd_ptr_q];
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // A retiring overflow wins over a clear on the same edge.
  always_comb begin
    sticky_d = sticky_q;
    if (load && alu_overflow) begin
      sticky_d = 1'b1;
    end else if (sticky_clear) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_tag_q    <= '0;
      sticky_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
      out_ovf_q    <= out_ovf_d;
      out_tag_q    <= out_tag_d;
      sticky_q     <= sticky_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_result      = out_result_q;
  assign out_carryout    = out_carry_q;
  assign out_zero        = out_zero_q;
  assign out_overflow    = out_ovf_q;
  assign out_tag         = out_tag_q;
  assign occupancy       = count_q;
  assign sticky_overflow = sticky_q;

endmodule
`default_nettype wire

// File: doc/alu_dispatch.md
# alu_dispatch

Operation buffer and result stage around the 32-bit combinational ALU in the execute path. Accepts (command, operandA, operandB, tag) operations over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents the FIFO head to the ALU, registers the ALU's result and flags into a one-entry output stage, and returns them in order over a second valid/ready handshake. It also keeps a sticky overflow flag for software-visible status.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TAGW, 4, tag width carried alongside each operation.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted this edge when in_valid & in_ready.
- in_command  input  3  ALU command.
- in_operand_a  input  32  operand A.
- in_operand_b  input  32  operand B.
- in_tag  input  TAGW  opaque tag, returned with the result.
- alu_command  output  3  to ALU command.
- alu_operand_a  output  32  to ALU operandA.
- alu_operand_b  output  32  to ALU operandB.
- alu_result  input  32  from ALU result.
- alu_carryout  input  1  from ALU carryout.
- alu_zero  input  1  from ALU zero.
- alu_overflow  input  1  from ALU overflow.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result this edge when out_valid & out_ready.
- out_result  output  32  registered result.
- out_carryout  output  1  registered carryout.
- out_zero  output  1  registered zero.
- out_overflow  output  1  registered overflow.
- out_tag  output  TAGW  tag of the result.
- occupancy  output  log2(DEPTH)+1  FIFO entry count; excludes the output stage.
- sticky_overflow  output  1  set by any retired overflow.
- sticky_clear  input  1  synchronous clear of sticky_overflow.

## Operation
- Command encoding:
  - 000 ADD, 001 SUB, 010 XOR, 011 SLT.
  - 100 AND, 101 NAND, 110 NOR, 111 OR.
  - The block passes the command through unmodified. The ALU gates carryout and overflow to 0 for commands other than ADD/SUB.
- FIFO:
  - Circular buffer with read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH. occupancy counts 0..DEPTH.
  - in_ready = (occupancy != DEPTH), combinational from registered count only.
  - When full, a push is refused even in a cycle where a pop occurs.
- ALU drive:
  - alu_* outputs equal the head entry combinationally.
  - When empty, alu_command=000 and alu_operand_a=alu_operand_b=0.
- Load condition: load = (occupancy≠0) & (!out_valid | out_ready).
  - On load, the head is popped and out_result/carryout/zero/overflow are captured from alu_* inputs; out_tag is captured from the head tag.
  - out_valid is set on load.
  - out_valid is cleared on out_valid & out_ready without a load.
- Simultaneous push and pop leave occupancy unchanged. There is no fall-through: an operation pushed into an empty FIFO cannot load on the same edge.
- While out_valid & !out_ready, all out_* fields hold stable.
- Results retire strictly in acceptance order.
- sticky_overflow:
  - Set on any load with alu_overflow=1.
  - Cleared by sticky_clear=1 at an edge.
  - Set beats clear on the same edge.

## Timing
- Reset (rst_n low, asynchronous): out_valid, all out_* fields, sticky_overflow, occupancy and both pointers go to 0. in_ready reads 1.
  - FIFO contents are discarded.
  - Reset mid-operation drops queued and held results with no later emission.
- Latency: an operation accepted at edge N, with FIFO empty and output stage free, loads at edge N+1. out_valid is high from N+1.
- Throughput: one operation per cycle sustained when in_valid=out_ready=1.
- Capacity before in_ready falls: DEPTH operations in the FIFO plus 1 in the output stage.
- Clock-to-out:
  - All out_* are registered.
  - alu_* and in_ready are combinational from state only, with no in_* to in_ready path.

## Test plan
- Reset: drive rst_n=0 mid-cycle, then release → out_valid=0, occupancy=0, in_ready=1, sticky_overflow=0.
- ADD 0x7FFFFFFF+0x00000001, tag 3, out_ready=1 → out_valid at edge N+1; out_result=0x80000000, overflow=1, carryout=0, zero=0, out_tag=3. sticky_overflow=1 from the same edge.
- Back-pressure, DEPTH=4, out_ready=0, 6 ADDs tagged 0..5 offered back-to-back:
  - Tags 0..4 are accepted; in_ready=0 with occupancy=4 while tag 5 waits.
  - out_tag=0 holds stable.
  - Raising out_ready retires tags 0..5 in order, one per cycle.
- Streaming, in_valid=out_ready=1:
  - SUB 5−5 → result 0, zero=1, carryout=1.
  - SLT 0xFFFFFFFF,1 → result 1.
  - NOR 0,0 → 0xFFFFFFFF.
  - XOR 0xF0F0F0F0,0xFF00FF00 → 0x0FF00FF0.
  - Back-to-back, one result per cycle.
- Sticky: sticky_clear on the same edge as an overflowing load → stays 1. sticky_clear on a later edge with no overflow → 0.
- Reset mid-stream with occupancy=3 and out_valid=1 → out_valid drops immediately; after release, no stale results appear and occupancy=0.
